// File: rtl/time_of_day_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_of_day_counter_pkg
// Brief    : BCD limits, reset time constants and BCD helpers for the clock.
// Revision : 1.0 - initial release
// ============================================================================
package time_of_day_counter_pkg;

    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HR24_MAX  = 8'h23;
    localparam logic [7:0] HR12_MAX  = 8'h12;
    localparam logic [7:0] HR12_MIN  = 8'h01;
    localparam logic [7:0] RST_HH_24 = 8'h00;
    localparam logic [7:0] RST_HH_12 = 8'h12;
    localparam logic [7:0] RST_MM    = 8'h00;
    localparam logic [7:0] RST_SS    = 8'h00;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
    endfunction

    // Argument is always below 100, so both quotient and remainder fit a nibble.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v % 7'd10);
        return {tens, units};
    endfunction

    function automatic logic bcd_digits_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter
// Brief    : Two-digit BCD counter MIN..MAX with variable increment and wrap carry.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
    import time_of_day_counter_pkg::*;
#(
    parameter logic [7:0] MAX     = 8'h59,
    parameter logic [7:0] MIN     = 8'h00,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       carry
);

    localparam logic [6:0] c_max_bin = bcd_to_bin(MAX);
    localparam logic [6:0] c_min_bin = bcd_to_bin(MIN);
    localparam logic [6:0] c_span    = c_max_bin - c_min_bin + 7'd1;

    logic [7:0] r_q;
    logic [6:0] w_sum;
    logic       w_wrap;
    logic [6:0] w_next;

    // Arithmetic in binary keeps the wrap a single compare for any increment.
    assign w_sum  = bcd_to_bin(r_q) + {3'b000, inc};
    assign w_wrap = (w_sum > c_max_bin);
    assign w_next = w_wrap ? (w_sum - c_span) : w_sum;
    assign carry  = en && w_wrap;
    assign q      = r_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (load) begin
            r_q <= load_val;
        end else if (en) begin
            r_q <= bin_to_bcd(w_next);
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_of_day_counter.sv
`default_nettype none
// ============================================================================
// Module   : time_of_day_counter
// Brief    : HH:MM:SS BCD time of day advanced by rising edges of a divided clock.
// Revision : 1.0 - initial release
// ============================================================================
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int MODE_24H = 1,
    parameter int SEC_STEP = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       hold,
    input  logic       set_en,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       set_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       min_pulse,
    output logic       day_pulse,
    output logic       set_err
);

    localparam logic [7:0] c_hr_max = (MODE_24H != 0) ? HR24_MAX  : HR12_MAX;
    localparam logic [7:0] c_hr_min = (MODE_24H != 0) ? 8'h00     : HR12_MIN;
    localparam logic [7:0] c_hr_rst = (MODE_24H != 0) ? RST_HH_24 : RST_HH_12;
    localparam logic [3:0] c_sec_inc = 4'(SEC_STEP);

    logic      r_tick_d;
    logic      r_min_pulse;
    logic      r_day_pulse;
    logic      r_set_err;
    logic      w_adv;
    logic      w_set_valid;
    logic      w_load;
    logic      w_ss_carry;
    logic      w_mm_carry;
    logic      w_hh_carry;
    logic      w_day;
    bcd_time_t w_set;

    assign w_set = '{hh: set_hh, mm: set_mm, ss: set_ss};

    // A set strobe swallows any tick edge arriving in the same cycle.
    assign w_adv = tick_in && !r_tick_d && !hold && !set_en;

    assign w_set_valid = bcd_digits_ok(w_set.hh) && bcd_digits_ok(w_set.mm)
                      && bcd_digits_ok(w_set.ss)
                      && (w_set.ss <= SEC_MAX) && (w_set.mm <= MIN_MAX)
                      && (w_set.hh <= c_hr_max) && (w_set.hh >= c_hr_min);
    assign w_load = set_en && w_set_valid;

    bcd_mod_counter #(.MAX(SEC_MAX), .MIN(8'h00), .RST_VAL(RST_SS)) u_ss (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (w_adv),
        .inc      (c_sec_inc),
        .load     (w_load),
        .load_val (w_set.ss),
        .q        (ss),
        .carry    (w_ss_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX), .MIN(8'h00), .RST_VAL(RST_MM)) u_mm (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (w_ss_carry),
        .inc      (4'd1),
        .load     (w_load),
        .load_val (w_set.mm),
        .q        (mm),
        .carry    (w_mm_carry)
    );

    bcd_mod_counter #(.MAX(c_hr_max), .MIN(c_hr_min), .RST_VAL(c_hr_rst)) u_hh (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (w_mm_carry),
        .inc      (4'd1),
        .load     (w_load),
        .load_val (w_set.hh),
        .q        (hh),
        .carry    (w_hh_carry)
    );

    generate
        if (MODE_24H != 0) begin : g_pm_24h
            logic w_unused_pm;
            assign w_unused_pm = set_pm;
            assign pm    = 1'b0;
            assign w_day = w_hh_carry;
        end else begin : g_pm_12h
            logic r_pm;
            logic w_unused_carry;
            logic w_to_noon;
            assign w_unused_carry = w_hh_carry;
            // 11 -> 12 is the am/pm boundary; 12 -> 01 leaves the flag alone.
            assign w_to_noon = w_mm_carry && (hh == 8'h11);
            assign w_day     = w_to_noon && r_pm;
            assign pm        = r_pm;
            always_ff @(posedge clk_in) begin
                if (reset) begin
                    r_pm <= 1'b0;
                end else if (w_load) begin
                    r_pm <= set_pm;
                end else if (w_to_noon) begin
                    r_pm <= !r_pm;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_tick_d    <= 1'b0;
            r_min_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_tick_d    <= tick_in;
            r_min_pulse <= w_ss_carry;
            r_day_pulse <= w_day;
            r_set_err   <= set_en && !w_set_valid;
        end
    end

    assign min_pulse = r_min_pulse;
    assign day_pulse = r_day_pulse;
    assign set_err   = r_set_err;

endmodule
`default_nettype wire

// File: tb/tb_time_of_day_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_of_day_counter
// Brief    : Scoreboard bench for 24h/step1, 12h/step1 and 24h/step8 variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_of_day_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tick, hold, set_en, set_pm;
    logic [7:0] set_hh, set_mm, set_ss;
    logic [7:0] hh_o [3];
    logic [7:0] mm_o [3];
    logic [7:0] ss_o [3];
    logic       pm_o [3];
    logic       mp_o [3];
    logic       dp_o [3];
    logic       er_o [3];

    time_of_day_counter #(.MODE_24H(1), .SEC_STEP(1)) dut24 (
        .clk_in(clk), .reset(reset), .tick_in(tick), .hold(hold), .set_en(set_en),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
        .hh(hh_o[0]), .mm(mm_o[0]), .ss(ss_o[0]), .pm(pm_o[0]),
        .min_pulse(mp_o[0]), .day_pulse(dp_o[0]), .set_err(er_o[0]));

    time_of_day_counter #(.MODE_24H(0), .SEC_STEP(1)) dut12 (
        .clk_in(clk), .reset(reset), .tick_in(tick), .hold(hold), .set_en(set_en),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
        .hh(hh_o[1]), .mm(mm_o[1]), .ss(ss_o[1]), .pm(pm_o[1]),
        .min_pulse(mp_o[1]), .day_pulse(dp_o[1]), .set_err(er_o[1]));

    time_of_day_counter #(.MODE_24H(1), .SEC_STEP(8)) dut8 (
        .clk_in(clk), .reset(reset), .tick_in(tick), .hold(hold), .set_en(set_en),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
        .hh(hh_o[2]), .mm(mm_o[2]), .ss(ss_o[2]), .pm(pm_o[2]),
        .min_pulse(mp_o[2]), .day_pulse(dp_o[2]), .set_err(er_o[2]));

    typedef struct {
        string      tag;
        int         idx;
        logic [7:0] hh, mm, ss;
        logic       pm, mp, dp, er;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic want(input string tag, input int idx, input logic [7:0] h, m, s,
                        input logic p, mp, dp, er);
        exp_t e;
        e.tag = tag; e.idx = idx; e.hh = h; e.mm = m; e.ss = s;
        e.pm = p; e.mp = mp; e.dp = dp; e.er = er;
        sb.push_back(e);
    endtask

    // One clock edge; everything queued for that edge is compared 1 ns later.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".hh"}, hh_o[e.idx], e.hh);
            chk({e.tag, ".mm"}, mm_o[e.idx], e.mm);
            chk({e.tag, ".ss"}, ss_o[e.idx], e.ss);
            chk({e.tag, ".pm"}, {7'b0, pm_o[e.idx]}, {7'b0, e.pm});
            chk({e.tag, ".min_pulse"}, {7'b0, mp_o[e.idx]}, {7'b0, e.mp});
            chk({e.tag, ".day_pulse"}, {7'b0, dp_o[e.idx]}, {7'b0, e.dp});
            chk({e.tag, ".set_err"}, {7'b0, er_o[e.idx]}, {7'b0, e.er});
        end
    endtask

    task automatic set_time(input logic [7:0] h, m, s, input logic p);
        set_hh = h; set_mm = m; set_ss = s; set_pm = p; set_en = 1'b1;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; hold = 1'b0; set_en = 1'b0; set_pm = 1'b0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
        @(posedge clk); #1;

        // Reset state of all variants
        want("rst24", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        want("rst12", 1, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        want("rst8",  2, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        step();
        reset = 1'b0;

        // First tick
        tick = 1'b1;
        want("tick1_24", 0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0);
        want("tick1_s8", 2, 8'h00, 8'h00, 8'h08, 0, 0, 0, 0);
        step();
        tick = 1'b0; step();

        // 23:59:58 rollover; 23 is not a legal 12h hour
        set_time(8'h23, 8'h59, 8'h58, 1'b0);
        want("set_2359", 0, 8'h23, 8'h59, 8'h58, 0, 0, 0, 0);
        want("set_bad12_23", 1, 8'h12, 8'h00, 8'h01, 0, 0, 0, 1);
        step();
        set_en = 1'b0;
        tick = 1'b1;
        want("roll_a", 0, 8'h23, 8'h59, 8'h59, 0, 0, 0, 0);
        want("s8_day_wrap", 2, 8'h00, 8'h00, 8'h06, 0, 1, 1, 0);
        step();
        tick = 1'b0; step();
        tick = 1'b1;
        want("roll_day", 0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0);
        step();
        want("roll_pulse_end", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        step();
        tick = 1'b0; step();

        // 12h mode: noon, 12 -> 01, midnight
        set_time(8'h11, 8'h59, 8'h59, 1'b0);
        want("set12_1159", 1, 8'h11, 8'h59, 8'h59, 0, 0, 0, 0);
        step();
        set_en = 1'b0; tick = 1'b1;
        want("h12_noon", 1, 8'h12, 8'h00, 8'h00, 1, 1, 0, 0);
        step();
        tick = 1'b0; step();
        set_time(8'h12, 8'h59, 8'h59, 1'b1);
        want("set12_1259", 1, 8'h12, 8'h59, 8'h59, 1, 0, 0, 0);
        step();
        set_en = 1'b0; tick = 1'b1;
        want("h12_to_01", 1, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0);
        step();
        tick = 1'b0; step();
        set_time(8'h11, 8'h59, 8'h59, 1'b1);
        step();
        set_en = 1'b0; tick = 1'b1;
        want("h12_midnight", 1, 8'h12, 8'h00, 8'h00, 0, 1, 1, 0);
        want("h24_1200", 0, 8'h12, 8'h00, 8'h00, 0, 1, 0, 0);
        step();
        tick = 1'b0; step();

        // Invalid sets leave time untouched
        set_time(8'h10, 8'h10, 8'h60, 1'b0);
        want("bad_ss60", 0, 8'h12, 8'h00, 8'h00, 0, 0, 0, 1);
        step();
        set_en = 1'b0;
        want("err_clears", 0, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        step();
        set_time(8'h1A, 8'h10, 8'h10, 1'b0);
        want("bad_hh1A", 0, 8'h12, 8'h00, 8'h00, 0, 0, 0, 1);
        step();
        set_time(8'h00, 8'h00, 8'h00, 1'b0);
        want("bad12_hh00", 1, 8'h12, 8'h00, 8'h00, 0, 0, 0, 1);
        want("ok24_hh00", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        step();
        set_en = 1'b0;

        // Collisions: set vs tick, hold, stuck-high tick
        set_time(8'h10, 8'h20, 8'h30, 1'b0);
        tick = 1'b1;
        want("set_wins", 0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0);
        step();
        set_en = 1'b0;
        want("set_edge_gone", 0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0);
        step();
        tick = 1'b0; step();
        hold = 1'b1; tick = 1'b1;
        want("hold_edge", 0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0);
        step();
        hold = 1'b0;
        want("hold_release", 0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0);
        step();
        tick = 1'b0; step();
        tick = 1'b1;
        want("stuck_first", 0, 8'h10, 8'h20, 8'h31, 0, 0, 0, 0);
        step();
        repeat (99) step();
        want("stuck_100", 0, 8'h10, 8'h20, 8'h31, 0, 0, 0, 0);
        step();
        tick = 1'b0; step();

        // SEC_STEP=8 minute carry, then reset mid-count
        set_time(8'h00, 8'h00, 8'h56, 1'b0);
        step();
        set_en = 1'b0; tick = 1'b1;
        want("s8_min_carry", 2, 8'h00, 8'h01, 8'h04, 0, 1, 0, 0);
        step();
        tick = 1'b0; step();
        tick = 1'b1;
        want("s8_next", 2, 8'h00, 8'h01, 8'h12, 0, 0, 0, 0);
        step();
        tick = 1'b0; step();
        reset = 1'b1; tick = 1'b1;
        set_time(8'h05, 8'h05, 8'h05, 1'b0);
        want("mid_rst24", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        want("mid_rst12", 1, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        want("mid_rst8",  2, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        step();
        reset = 1'b0; set_en = 1'b0; tick = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
